// File: rtl/idex_operand_stage_if.sv
// ID/EX operand stage bus: decoded ID instruction and forwarding sources in,
// stall request and registered EX operands/control out.
interface idex_operand_stage_if #(
    parameter int WORD_LEN   = 32,
    parameter int REG_ADDR_W = 5
);
    // Decoded instruction from ID
    logic                  id_valid;
    logic [WORD_LEN-1:0]   id_pc;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic [WORD_LEN-1:0]   id_rs1_data;
    logic [WORD_LEN-1:0]   id_rs2_data;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [WORD_LEN-1:0]   id_imm;
    logic [1:0]            id_asel;
    logic                  id_bsel;
    logic [3:0]            id_alu_op;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_reg_write;
    logic                  id_mem_read;
    // Forwarding sources from later stages
    logic [WORD_LEN-1:0]   ex_alu_result;
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic                  mem_reg_write;
    logic [WORD_LEN-1:0]   mem_result;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic                  wb_reg_write;
    logic [WORD_LEN-1:0]   wb_result;
    // Pipeline control
    logic                  flush;
    logic                  hold_ex;
    logic                  stall_id;
    // EX stage registers
    logic                  ex_valid;
    logic [WORD_LEN-1:0]   ex_a;
    logic [WORD_LEN-1:0]   ex_b;
    logic [3:0]            ex_alu_op;
    logic [WORD_LEN-1:0]   ex_store_data;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_reg_write;
    logic                  ex_mem_read;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_use_rs1, id_use_rs2, id_imm, id_asel, id_bsel, id_alu_op,
               id_rd_addr, id_reg_write, id_mem_read,
               ex_alu_result, mem_rd_addr, mem_reg_write, mem_result,
               wb_rd_addr, wb_reg_write, wb_result, flush, hold_ex,
        input  stall_id, ex_valid, ex_a, ex_b, ex_alu_op, ex_store_data,
               ex_rd_addr, ex_reg_write, ex_mem_read
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_use_rs1, id_use_rs2, id_imm, id_asel, id_bsel, id_alu_op,
               id_rd_addr, id_reg_write, id_mem_read,
               ex_alu_result, mem_rd_addr, mem_reg_write, mem_result,
               wb_rd_addr, wb_reg_write, wb_result, flush, hold_ex,
        output stall_id, ex_valid, ex_a, ex_b, ex_alu_op, ex_store_data,
               ex_rd_addr, ex_reg_write, ex_mem_read
    );
endinterface

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline stage in front of the ALU. Resolves operand forwarding
// (EX > MEM > WB > regfile), selects ALU operands, detects load-use hazards
// and registers the result into the EX stage with flush/hold/bubble control.
module idex_operand_stage #(
    parameter int WORD_LEN   = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic                 clk,
    input logic                 rstn,
    idex_operand_stage_if.slave bus
);

    // Youngest-writer-wins forwarding; x0 is hard-wired to zero.
    function automatic logic [WORD_LEN-1:0] fwd_operand(
        input logic [REG_ADDR_W-1:0] src,
        input logic [WORD_LEN-1:0]   rf_data,
        input logic                  ex_fwd_en,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [WORD_LEN-1:0]   ex_val,
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic [WORD_LEN-1:0]   mem_val,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [WORD_LEN-1:0]   wb_val
    );
        if (src == '0)                          return '0;
        else if (ex_fwd_en && (ex_rd == src))   return ex_val;
        else if (mem_we && (mem_rd == src))     return mem_val;
        else if (wb_we && (wb_rd == src))       return wb_val;
        else                                    return rf_data;
    endfunction

    logic                  ex_valid_q,      ex_valid_d;
    logic [WORD_LEN-1:0]   ex_a_q,          ex_a_d;
    logic [WORD_LEN-1:0]   ex_b_q,          ex_b_d;
    logic [3:0]            ex_alu_op_q,     ex_alu_op_d;
    logic [WORD_LEN-1:0]   ex_store_data_q, ex_store_data_d;
    logic [REG_ADDR_W-1:0] ex_rd_addr_q,    ex_rd_addr_d;
    logic                  ex_reg_write_q,  ex_reg_write_d;
    logic                  ex_mem_read_q,   ex_mem_read_d;

    logic                  ex_fwd_en;
    logic [WORD_LEN-1:0]   fwd_rs1;
    logic [WORD_LEN-1:0]   fwd_rs2;
    logic [WORD_LEN-1:0]   op_a;
    logic [WORD_LEN-1:0]   op_b;
    logic                  load_use;
    logic                  stall_id;

    // Operand resolution, hazard detection and stall request.
    always_comb begin
        // A load in EX has no data yet, so it must never forward from the ALU.
        ex_fwd_en = ex_valid_q & ex_reg_write_q & ~ex_mem_read_q;

        fwd_rs1 = fwd_operand(bus.id_rs1_addr, bus.id_rs1_data,
                              ex_fwd_en, ex_rd_addr_q, bus.ex_alu_result,
                              bus.mem_reg_write, bus.mem_rd_addr, bus.mem_result,
                              bus.wb_reg_write, bus.wb_rd_addr, bus.wb_result);
        fwd_rs2 = fwd_operand(bus.id_rs2_addr, bus.id_rs2_data,
                              ex_fwd_en, ex_rd_addr_q, bus.ex_alu_result,
                              bus.mem_reg_write, bus.mem_rd_addr, bus.mem_result,
                              bus.wb_reg_write, bus.wb_rd_addr, bus.wb_result);

        case (bus.id_asel)
            2'd0:    op_a = fwd_rs1;
            2'd1:    op_a = bus.id_pc;
            default: op_a = '0;
        endcase
        op_b = bus.id_bsel ? bus.id_imm : fwd_rs2;

        load_use = bus.id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_addr_q != '0) &
                   ((bus.id_use_rs1 & (bus.id_rs1_addr == ex_rd_addr_q)) |
                    (bus.id_use_rs2 & (bus.id_rs2_addr == ex_rd_addr_q)));

        // A flush discards the ID instruction, so there is nothing to hold.
        stall_id = rstn & ~bus.flush & (bus.hold_ex | load_use);
    end

    // Next EX state: flush > hold > load-use bubble > capture.
    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_a_d          = ex_a_q;
        ex_b_d          = ex_b_q;
        ex_alu_op_d     = ex_alu_op_q;
        ex_store_data_d = ex_store_data_q;
        ex_rd_addr_d    = ex_rd_addr_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;

        if (bus.flush || (!bus.hold_ex && (load_use || !bus.id_valid))) begin
            ex_valid_d      = 1'b0;
            ex_a_d          = '0;
            ex_b_d          = '0;
            ex_alu_op_d     = '0;
            ex_store_data_d = '0;
            ex_rd_addr_d    = '0;
            ex_reg_write_d  = 1'b0;
            ex_mem_read_d   = 1'b0;
        end else if (!bus.hold_ex) begin
            ex_valid_d      = 1'b1;
            ex_a_d          = op_a;
            ex_b_d          = op_b;
            ex_alu_op_d     = bus.id_alu_op;
            ex_store_data_d = fwd_rs2;
            ex_rd_addr_d    = bus.id_rd_addr;
            ex_reg_write_d  = bus.id_reg_write;
            ex_mem_read_d   = bus.id_mem_read;
        end
    end

    // EX stage registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ex_valid_q      <= 1'b0;
            ex_a_q          <= '0;
            ex_b_q          <= '0;
            ex_alu_op_q     <= '0;
            ex_store_data_q <= '0;
            ex_rd_addr_q    <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_a_q          <= ex_a_d;
            ex_b_q          <= ex_b_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_store_data_q <= ex_store_data_d;
            ex_rd_addr_q    <= ex_rd_addr_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
        end
    end

    assign bus.stall_id      = stall_id;
    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_a          = ex_a_q;
    assign bus.ex_b          = ex_b_q;
    assign bus.ex_alu_op     = ex_alu_op_q;
    assign bus.ex_store_data = ex_store_data_q;
    assign bus.ex_rd_addr    = ex_rd_addr_q;
    assign bus.ex_reg_write  = ex_valid_q & ex_reg_write_q;
    assign bus.ex_mem_read   = ex_valid_q & ex_mem_read_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: each step drives ID and forwarding
// inputs, queues the expected EX contents, and compares after the next edge.
module tb_idex_operand_stage;

    logic clk = 1'b0;
    logic rstn;

    idex_operand_stage_if #(.WORD_LEN(32), .REG_ADDR_W(5)) bus ();

    idex_operand_stage #(.WORD_LEN(32), .REG_ADDR_W(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  alu_op;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic v, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] sd,
                            input logic [4:0] rd, input logic rw, input logic mr);
        exp_t e;
        e.valid = v; e.a = a; e.b = b; e.alu_op = op;
        e.store = sd; e.rd = rd; e.rw = rw; e.mr = mr;
        exp_q.push_back(e);
    endtask

    task automatic push_bubble();
        push_exp(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_stall(input string tag, input logic expv);
        #2;
        cmp(tag, {31'b0, bus.stall_id}, {31'b0, expv});
    endtask

    task automatic step_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        cmp({tag, ".ex_valid"},      {31'b0, bus.ex_valid},     {31'b0, e.valid});
        cmp({tag, ".ex_a"},          bus.ex_a,                  e.a);
        cmp({tag, ".ex_b"},          bus.ex_b,                  e.b);
        cmp({tag, ".ex_alu_op"},     {28'b0, bus.ex_alu_op},    {28'b0, e.alu_op});
        cmp({tag, ".ex_store_data"}, bus.ex_store_data,         e.store);
        cmp({tag, ".ex_rd_addr"},    {27'b0, bus.ex_rd_addr},   {27'b0, e.rd});
        cmp({tag, ".ex_reg_write"},  {31'b0, bus.ex_reg_write}, {31'b0, e.rw});
        cmp({tag, ".ex_mem_read"},   {31'b0, bus.ex_mem_read},  {31'b0, e.mr});
    endtask

    task automatic clear_inputs();
        bus.id_valid = 0;      bus.id_pc = 0;
        bus.id_rs1_addr = 0;   bus.id_rs2_addr = 0;
        bus.id_rs1_data = 0;   bus.id_rs2_data = 0;
        bus.id_use_rs1 = 0;    bus.id_use_rs2 = 0;
        bus.id_imm = 0;        bus.id_asel = 0;       bus.id_bsel = 0;
        bus.id_alu_op = 0;     bus.id_rd_addr = 0;
        bus.id_reg_write = 0;  bus.id_mem_read = 0;
        bus.ex_alu_result = 0;
        bus.mem_rd_addr = 0;   bus.mem_reg_write = 0; bus.mem_result = 0;
        bus.wb_rd_addr = 0;    bus.wb_reg_write = 0;  bus.wb_result = 0;
        bus.flush = 0;         bus.hold_ex = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a valid instruction present; stall must stay low.
        rstn = 0;
        clear_inputs();
        bus.id_valid = 1; bus.id_rs1_addr = 1; bus.id_use_rs1 = 1;
        bus.id_rd_addr = 3; bus.id_reg_write = 1; bus.id_imm = 32'h44; bus.id_alu_op = 4'h5;
        push_bubble(); chk_stall("rst0.stall", 1'b0); step_check("rst0");
        bus.hold_ex = 1;
        push_bubble(); chk_stall("rst1.stall", 1'b0); step_check("rst1");

        // Writer of x5 (LUI-style, a=0, b=imm).
        rstn = 1;
        clear_inputs();
        bus.id_valid = 1; bus.id_asel = 2; bus.id_bsel = 1; bus.id_imm = 32'h10;
        bus.id_alu_op = 4'h3; bus.id_rd_addr = 5; bus.id_reg_write = 1;
        push_exp(1, 32'h0, 32'h10, 4'h3, 32'h0, 5'd5, 1, 0);
        chk_stall("A.stall", 1'b0); step_check("A");

        // EX forwarding beats the regfile.
        clear_inputs();
        bus.ex_alu_result = 32'h10;
        bus.id_valid = 1; bus.id_rs1_addr = 5; bus.id_use_rs1 = 1; bus.id_rs1_data = 32'hDEAD;
        bus.id_asel = 0; bus.id_bsel = 1; bus.id_imm = 32'h4; bus.id_alu_op = 4'h0;
        bus.id_rd_addr = 6; bus.id_reg_write = 1;
        push_exp(1, 32'h10, 32'h4, 4'h0, 32'h0, 5'd6, 1, 0);
        chk_stall("B.stall", 1'b0); step_check("B");

        // Writer of x5 again.
        clear_inputs();
        bus.id_valid = 1; bus.id_asel = 2; bus.id_bsel = 1; bus.id_imm = 32'h10;
        bus.id_alu_op = 4'h3; bus.id_rd_addr = 5; bus.id_reg_write = 1;
        push_exp(1, 32'h0, 32'h10, 4'h3, 32'h0, 5'd5, 1, 0);
        step_check("C");

        // EX, MEM and WB all write x5: EX wins on both sources.
        clear_inputs();
        bus.ex_alu_result = 32'h10;
        bus.mem_rd_addr = 5; bus.mem_reg_write = 1; bus.mem_result = 32'h20;
        bus.wb_rd_addr = 5;  bus.wb_reg_write = 1;  bus.wb_result = 32'h30;
        bus.id_valid = 1; bus.id_rs1_addr = 5; bus.id_use_rs1 = 1; bus.id_rs1_data = 32'hDEAD;
        bus.id_rs2_addr = 5; bus.id_use_rs2 = 1; bus.id_rs2_data = 32'hBEEF;
        bus.id_asel = 0; bus.id_bsel = 0; bus.id_rd_addr = 8; bus.id_reg_write = 1;
        push_exp(1, 32'h10, 32'h10, 4'h0, 32'h10, 5'd8, 1, 0);
        step_check("D");

        // EX (x8) misses: rs1 from MEM, rs2 from WB. Writes x0.
        clear_inputs();
        bus.ex_alu_result = 32'h99;
        bus.mem_rd_addr = 5; bus.mem_reg_write = 1; bus.mem_result = 32'h20;
        bus.wb_rd_addr = 9;  bus.wb_reg_write = 1;  bus.wb_result = 32'h30;
        bus.id_valid = 1; bus.id_rs1_addr = 5; bus.id_use_rs1 = 1; bus.id_rs1_data = 32'h1;
        bus.id_rs2_addr = 9; bus.id_use_rs2 = 1; bus.id_rs2_data = 32'h2;
        bus.id_asel = 0; bus.id_bsel = 0; bus.id_alu_op = 4'h2;
        bus.id_rd_addr = 0; bus.id_reg_write = 1;
        push_exp(1, 32'h20, 32'h30, 4'h2, 32'h30, 5'd0, 1, 0);
        step_check("E");

        // x0 sources read 0 despite every stage writing rd=0. Instruction is a load to x7.
        clear_inputs();
        bus.ex_alu_result = 32'h77;
        bus.mem_rd_addr = 0; bus.mem_reg_write = 1; bus.mem_result = 32'h66;
        bus.wb_rd_addr = 0;  bus.wb_reg_write = 1;  bus.wb_result = 32'h44;
        bus.id_valid = 1; bus.id_rs1_addr = 0; bus.id_use_rs1 = 1; bus.id_rs1_data = 32'h1234;
        bus.id_rs2_addr = 0; bus.id_rs2_data = 32'h5678;
        bus.id_asel = 0; bus.id_bsel = 1; bus.id_imm = 32'h8;
        bus.id_rd_addr = 7; bus.id_reg_write = 1; bus.id_mem_read = 1;
        push_exp(1, 32'h0, 32'h8, 4'h0, 32'h0, 5'd7, 1, 1);
        step_check("F");

        // Load-use on rs2: stall and bubble.
        clear_inputs();
        bus.ex_alu_result = 32'h400;
        bus.id_valid = 1; bus.id_rs1_addr = 3; bus.id_use_rs1 = 1; bus.id_rs1_data = 32'h3;
        bus.id_rs2_addr = 7; bus.id_use_rs2 = 1; bus.id_rs2_data = 32'hBAD;
        bus.id_asel = 0; bus.id_bsel = 0; bus.id_alu_op = 4'h1;
        bus.id_rd_addr = 9; bus.id_reg_write = 1;
        push_bubble(); chk_stall("G.stall", 1'b1); step_check("G");

        // Load now in MEM: forwarded load data, instruction proceeds.
        bus.ex_alu_result = 32'h0;
        bus.mem_rd_addr = 7; bus.mem_reg_write = 1; bus.mem_result = 32'h55;
        push_exp(1, 32'h3, 32'h55, 4'h1, 32'h55, 5'd9, 1, 0);
        chk_stall("H.stall", 1'b0); step_check("H");

        // Another load to x10.
        clear_inputs();
        bus.id_valid = 1; bus.id_asel = 0; bus.id_bsel = 1;
        bus.id_rd_addr = 10; bus.id_reg_write = 1; bus.id_mem_read = 1;
        push_exp(1, 32'h0, 32'h0, 4'h0, 32'h0, 5'd10, 1, 1);
        step_check("I");

        // Load-use coincides with flush: no stall, bubble.
        clear_inputs();
        bus.id_valid = 1; bus.id_rs1_addr = 10; bus.id_use_rs1 = 1;
        bus.id_rd_addr = 11; bus.id_reg_write = 1; bus.flush = 1;
        push_bubble(); chk_stall("J.stall", 1'b0); step_check("J");

        // AUIPC.
        clear_inputs();
        bus.id_valid = 1; bus.id_pc = 32'h100; bus.id_imm = 32'h1000;
        bus.id_asel = 1; bus.id_bsel = 1; bus.id_rd_addr = 11; bus.id_reg_write = 1;
        push_exp(1, 32'h100, 32'h1000, 4'h0, 32'h0, 5'd11, 1, 0);
        step_check("K");

        // Hold EX for three cycles: AUIPC stays, stall asserted.
        clear_inputs();
        bus.ex_alu_result = 32'h1100;
        bus.id_valid = 1; bus.id_rs1_addr = 11; bus.id_use_rs1 = 1; bus.id_rs1_data = 32'h7;
        bus.id_asel = 0; bus.id_bsel = 1; bus.id_imm = 32'h1; bus.id_alu_op = 4'h2;
        bus.id_rd_addr = 12; bus.id_reg_write = 1; bus.hold_ex = 1;
        for (int i = 0; i < 3; i++) begin
            push_exp(1, 32'h100, 32'h1000, 4'h0, 32'h0, 5'd11, 1, 0);
            chk_stall("L.stall", 1'b1); step_check("L.hold");
        end
        bus.hold_ex = 0;
        push_exp(1, 32'h1100, 32'h1, 4'h2, 32'h0, 5'd12, 1, 0);
        chk_stall("L4.stall", 1'b0); step_check("L.release");

        // id_valid=0 gives a bubble even with control bits set.
        clear_inputs();
        bus.id_valid = 0; bus.id_reg_write = 1; bus.id_mem_read = 1;
        bus.id_rd_addr = 13; bus.id_imm = 32'h9; bus.id_bsel = 1; bus.id_alu_op = 4'h7;
        push_bubble(); chk_stall("M.stall", 1'b0); step_check("M");

        // asel=3 selects zero.
        clear_inputs();
        bus.id_valid = 1; bus.id_rs1_addr = 4; bus.id_use_rs1 = 1; bus.id_rs1_data = 32'hAAAA;
        bus.id_asel = 3; bus.id_bsel = 0; bus.id_alu_op = 4'hF; bus.id_rd_addr = 14;
        push_exp(1, 32'h0, 32'h0, 4'hF, 32'h0, 5'd14, 0, 0);
        step_check("N");

        // EX targets x14 but does not write: no forwarding.
        clear_inputs();
        bus.ex_alu_result = 32'hBAD0;
        bus.id_valid = 1; bus.id_rs1_addr = 14; bus.id_use_rs1 = 1; bus.id_rs1_data = 32'hCAFE;
        bus.id_asel = 0; bus.id_bsel = 1; bus.id_imm = 32'h2; bus.id_alu_op = 4'h1;
        bus.id_rd_addr = 15; bus.id_reg_write = 1;
        push_exp(1, 32'hCAFE, 32'h2, 4'h1, 32'h0, 5'd15, 1, 0);
        step_check("O");

        // Reset mid-run clears the stage.
        rstn = 0;
        bus.hold_ex = 1;
        push_bubble(); chk_stall("P.stall", 1'b0); step_check("P");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
